// File: rtl/oldland_dbg_reg_xfer.sv
// oldland_dbg_reg_xfer: sequences single debug register reads/writes onto the register file debug port.
// Define OLDLAND_DBG_REG_READBACK_EN to read back and verify every write.
module oldland_dbg_reg_xfer #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [3:0]               req_sel,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  input  logic                     cpu_halted,
  output logic                     dbg_en,
  output logic [3:0]               dbg_reg_sel,
  output logic [31:0]              dbg_reg_wr_val,
  output logic                     dbg_reg_wr_en,
  input  logic [31:0]              dbg_reg_val,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
`ifdef OLDLAND_DBG_REG_READBACK_EN
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, VERIFY, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
`endif
  state_t state, state_nxt;
  logic wr;
  logic accept;
  assign accept = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign dbg_en = state != IDLE && state != RESP;
  assign dbg_reg_wr_en = state == ACCESS && wr;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = cpu_halted ? ACCESS : RESP;
`ifdef OLDLAND_DBG_REG_READBACK_EN
      ACCESS:  state_nxt = cpu_halted ? CAPTURE : RESP;
      CAPTURE: state_nxt = cpu_halted && wr ? VERIFY : RESP;
      VERIFY:  state_nxt = RESP;
`else
      ACCESS:  state_nxt = cpu_halted && !wr ? CAPTURE : RESP;
      CAPTURE: state_nxt = RESP;
`endif
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr <= 1'b0;
      dbg_reg_sel <= '0;
      dbg_reg_wr_val <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr <= req_wr;
        dbg_reg_sel <= req_sel;
        dbg_reg_wr_val <= req_wdata;
        rsp_rdata <= '0;
        rsp_err <= !cpu_halted;
      end else if (dbg_en && !cpu_halted) begin
        rsp_rdata <= '0;
        rsp_err <= 1'b1;
      end else if (state == CAPTURE) begin
        rsp_rdata <= dbg_reg_val;
`ifdef OLDLAND_DBG_REG_READBACK_EN
      end else if (state == VERIFY) begin
        rsp_rdata <= dbg_reg_val;
        rsp_err <= dbg_reg_val != dbg_reg_wr_val;
`endif
      end
      if (rsp_valid && rsp_ready && rsp_err && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_oldland_dbg_reg_xfer.sv
// tb_oldland_dbg_reg_xfer: transaction-level model plus directed vectors for the debug register sequencer.
module tb_oldland_dbg_reg_xfer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cpu_halted = 1'b1;
  logic        dbg_en;
  logic [3:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_wr_val;
  logic        dbg_reg_wr_en;
  logic [31:0] dbg_reg_val = '0;
  logic [7:0]  err_count;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  oldland_dbg_reg_xfer #(.ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_sel(req_sel), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cpu_halted(cpu_halted), .dbg_en(dbg_en),
    .dbg_reg_sel(dbg_reg_sel), .dbg_reg_wr_val(dbg_reg_wr_val), .dbg_reg_wr_en(dbg_reg_wr_en),
    .dbg_reg_val(dbg_reg_val), .err_count(err_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  // Register file with registered read; corrupt forces a stored value that differs from the write data.
  logic [31:0] rf [16];
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (dbg_reg_wr_en) rf[dbg_reg_sel] <= corrupt ? dbg_reg_wr_val ^ 32'h1 : dbg_reg_wr_val;
    dbg_reg_val <= rf[dbg_reg_sel];
  end
`ifdef OLDLAND_DBG_REG_READBACK_EN
  localparam int LWR = 4;
`else
  localparam int LWR = 2;
`endif
  // Transaction model: phase 0 idle, 1 touching the register file, 2 response pending.
  int          phase = 0;
  int          k = 0;
  int          lat_tgt = 0;
  int          m_cnt = 0;
  logic        m_wr = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic [31:0] m_regs [16];
  initial for (int i = 0; i < 16; i++) begin
    rf[i] = 32'h11111111 * i;
    m_regs[i] = 32'h11111111 * i;
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0; m_cnt = 0; m_wr = 1'b0; m_sel = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    end else if (phase == 0) begin
      if (req_valid) begin
        m_wr = req_wr; m_sel = req_sel; m_wdata = req_wdata; k = 0;
        lat_tgt = req_wr ? LWR : 3;
        m_err = !cpu_halted;
        m_rdata = (cpu_halted && !req_wr) ? m_regs[req_sel] : 32'h0;
`ifdef OLDLAND_DBG_REG_READBACK_EN
        if (cpu_halted && req_wr) begin
          m_rdata = corrupt ? req_wdata ^ 32'h1 : req_wdata;
          m_err = corrupt;
        end
`endif
        phase = cpu_halted ? 1 : 2;
      end
    end else if (phase == 1) begin
      if (k == 0 && m_wr) m_regs[m_sel] = corrupt ? m_wdata ^ 32'h1 : m_wdata;
      k++;
      if (!cpu_halted) begin
        phase = 2; m_err = 1'b1; m_rdata = '0;
      end else if (k == lat_tgt - 1) phase = 2;
    end else if (rsp_ready) begin
      phase = 0;
      if (m_err && m_cnt < 255) m_cnt++;
    end
  end
  always @(posedge clk) begin
    #1;
    chk("req_ready", req_ready, phase == 0);
    chk("rsp_valid", rsp_valid, phase == 2);
    chk("dbg_en", dbg_en, phase == 1);
    chk("dbg_reg_wr_en", dbg_reg_wr_en, phase == 1 && k == 0 && m_wr);
    chk("dbg_reg_sel", dbg_reg_sel, m_sel);
    chk("dbg_reg_wr_val", dbg_reg_wr_val, m_wdata);
    chk("err_count", err_count, m_cnt);
    if (phase == 2) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
  end
  task automatic xact(input logic w, input logic [3:0] s, input logic [31:0] d, input logic halt,
                      input int drop_at, input int hold, output int lat, output logic [31:0] rd,
                      output logic er);
    @(negedge clk);
    cpu_halted = halt; req_valid = 1'b1; req_wr = w; req_sel = s; req_wdata = d; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      if (lat == drop_at) cpu_halted = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("rsp_timeout", rsp_valid, 1'b1);
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cpu_halted = 1'b1;
  endtask
  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_dbg_en", dbg_en, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    rst_n = 1'b1;
    xact(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 0, 0, lat, rd, er);
    chk("wr5_lat", lat, LWR);
    chk("wr5_err", er, 1'b0);
    xact(1'b0, 4'd5, 32'h0, 1'b1, 0, 0, lat, rd, er);
    chk("rd5_lat", lat, 3);
    chk("rd5_data", rd, 32'hDEADBEEF);
    chk("rd5_err", er, 1'b0);
    xact(1'b0, 4'd3, 32'h0, 1'b0, 0, 0, lat, rd, er);
    chk("nohalt_lat", lat, 1);
    chk("nohalt_data", rd, 32'h0);
    chk("nohalt_err", er, 1'b1);
    chk("nohalt_cnt", err_count, 8'd1);
    xact(1'b0, 4'd15, 32'h0, 1'b1, 0, 5, lat, rd, er);
    chk("rd15_data", rd, 32'hFFFFFFFF);
    chk("rd15_err", er, 1'b0);
    xact(1'b0, 4'd2, 32'h0, 1'b1, 2, 0, lat, rd, er);
    chk("drop_cap_lat", lat, 3);
    chk("drop_cap_data", rd, 32'h0);
    chk("drop_cap_err", er, 1'b1);
    chk("drop_cap_cnt", err_count, 8'd2);
    xact(1'b1, 4'd6, 32'h0BADF00D, 1'b1, 1, 0, lat, rd, er);
    chk("drop_acc_lat", lat, 2);
    chk("drop_acc_err", er, 1'b1);
    xact(1'b0, 4'd6, 32'h0, 1'b1, 0, 0, lat, rd, er);
    chk("rd6_data", rd, 32'h0BADF00D);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_sel = 4'd9; req_wdata = 32'hAAAA5555;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("acc_dbg_en", dbg_en, 1'b1);
    chk("acc_wr_en", dbg_reg_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_dbg_en", dbg_en, 1'b0);
    chk("arst_wr_en", dbg_reg_wr_en, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_err_count", err_count, 8'd0);
    xact(1'b0, 4'd9, 32'h0, 1'b1, 0, 0, lat, rd, er);
    chk("rd9_data", rd, 32'h99999999);
    xact(1'b1, 4'd7, 32'h12345678, 1'b1, 0, 0, lat, rd, er);
`ifdef OLDLAND_DBG_REG_READBACK_EN
    chk("wr7_lat", lat, 4);
    chk("wr7_data", rd, 32'h12345678);
    chk("wr7_err", er, 1'b0);
    corrupt = 1'b1;
    xact(1'b1, 4'd8, 32'hCAFE0000, 1'b1, 0, 0, lat, rd, er);
    corrupt = 1'b0;
    chk("wr8_bad_err", er, 1'b1);
    chk("wr8_bad_data", rd, 32'hCAFE0001);
`else
    chk("wr7_lat", lat, 2);
    chk("wr7_data", rd, 32'h0);
    chk("wr7_err", er, 1'b0);
`endif
    for (int i = 0; i < 260; i++) xact(1'b0, 4'd1, 32'h0, 1'b0, 0, 0, lat, rd, er);
    chk("sat_cnt", err_count, 8'hFF);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
